// File: rtl/gberet_vidbus_if.sv
// CPU-side video bus: Z80 memory cycle toward the video block and read-data return.
interface gberet_vidbus_if;
   logic        CPUMX;
   logic [15:0] CPUAD;
   logic        CPUWR;
   logic [7:0]  CPUWD;
   logic        VIDDV;
   logic [7:0]  VIDRD;

   modport master (output CPUMX, CPUAD, CPUWR, CPUWD, input VIDDV, VIDRD);
   modport slave  (input CPUMX, CPUAD, CPUWR, CPUWD, output VIDDV, VIDRD);
endinterface

// File: rtl/gberet_vidbus.sv
// Green Beret video bus responder: colour/code/work RAM, scroll, sprite bank and flip
// registers, CPU read-back and parallel fetch ports for the renderers.
module gberet_vidbus (
   input  logic              CL,
   input  logic              RESET,
   gberet_vidbus_if.slave    bus,
   input  logic [10:0]       VADR,
   output logic [7:0]        VCOL,
   output logic [7:0]        VCOD,
   input  logic [7:0]        SADR,
   output logic [7:0]        SPDT,
   input  logic [4:0]        ROW,
   output logic [8:0]        SCRL,
   output logic              SPBK,
   output logic              FLIP
);

   logic hit_col, hit_code, hit_work, hit_slo, hit_shi, hit_bank, hit_flip, hit;
   logic wr, wr_q, commit;

   logic [7:0]  col_ram  [0:2047];
   logic [7:0]  code_ram [0:2047];
   logic [7:0]  work_ram [0:4095];
   logic [7:0]  scrl_lo  [0:31];
   logic [31:0] scrl_hi;

   always_comb begin
      hit_col  = (bus.CPUAD[15:11] == 5'b11000);
      hit_code = (bus.CPUAD[15:11] == 5'b11001);
      hit_work = (bus.CPUAD[15:12] == 4'hD);
      hit_slo  = (bus.CPUAD[15:5]  == 11'h700);
      hit_shi  = (bus.CPUAD[15:5]  == 11'h701);
      hit_bank = (bus.CPUAD == 16'hE043);
      hit_flip = (bus.CPUAD == 16'hE044);
      hit      = hit_col | hit_code | hit_work | hit_slo | hit_shi | hit_bank | hit_flip;
   end

   // A held strobe commits only on its rising edge; reset forces the edge
   // register low so a strobe surviving reset still commits once afterwards.
   assign wr     = bus.CPUMX & bus.CPUWR & hit;
   assign commit = wr & ~wr_q & ~RESET;

   always_ff @(posedge CL) begin
      if (RESET) wr_q <= 1'b0;
      else       wr_q <= wr;
   end

   assign bus.VIDDV = bus.CPUMX & ~bus.CPUWR & (bus.CPUAD[15:13] == 3'b110);

   always_ff @(posedge CL) begin
      if (commit && hit_col)  col_ram[bus.CPUAD[10:0]]  <= bus.CPUWD;
      if (commit && hit_code) code_ram[bus.CPUAD[10:0]] <= bus.CPUWD;
      if (commit && hit_work) work_ram[bus.CPUAD[11:0]] <= bus.CPUWD;
   end

   always_ff @(posedge CL) begin
      if (RESET) begin
         for (int unsigned i = 0; i < 32; i++) scrl_lo[i] <= '0;
         scrl_hi <= '0;
         SPBK    <= 1'b0;
         FLIP    <= 1'b0;
      end else if (commit) begin
         if (hit_slo)  scrl_lo[bus.CPUAD[4:0]] <= bus.CPUWD;
         if (hit_shi)  scrl_hi[bus.CPUAD[4:0]] <= bus.CPUWD[0];
         if (hit_bank) SPBK <= bus.CPUWD[3];
         if (hit_flip) FLIP <= bus.CPUWD[3];
      end
   end

   // Read ports sample before the same-edge write lands, so a collision returns old data.
   always_ff @(posedge CL) begin
      if (RESET) begin
         bus.VIDRD <= '0;
         VCOL      <= '0;
         VCOD      <= '0;
         SPDT      <= '0;
         SCRL      <= '0;
      end else begin
         if (hit_col)       bus.VIDRD <= col_ram[bus.CPUAD[10:0]];
         else if (hit_code) bus.VIDRD <= code_ram[bus.CPUAD[10:0]];
         else if (hit_work) bus.VIDRD <= work_ram[bus.CPUAD[11:0]];
         else               bus.VIDRD <= '0;
         VCOL <= col_ram[VADR];
         VCOD <= code_ram[VADR];
         SPDT <= work_ram[{3'b000, SPBK, SADR}];
         SCRL <= {scrl_hi[ROW], scrl_lo[ROW]};
      end
   end

endmodule

// File: tb/tb_gberet_vidbus.sv
// Directed plus randomized checks of gberet_vidbus against a byte-level memory-map model.
module tb_gberet_vidbus;

   logic        CL = 1'b0;
   logic        RESET;
   logic [10:0] VADR;
   logic [7:0]  VCOL, VCOD, SADR, SPDT;
   logic [4:0]  ROW;
   logic [8:0]  SCRL;
   logic        SPBK, FLIP;

   gberet_vidbus_if vif ();

   gberet_vidbus dut (
      .CL(CL), .RESET(RESET), .bus(vif),
      .VADR(VADR), .VCOL(VCOL), .VCOD(VCOD),
      .SADR(SADR), .SPDT(SPDT),
      .ROW(ROW), .SCRL(SCRL), .SPBK(SPBK), .FLIP(FLIP)
   );

   always #5 CL = ~CL;

   int total = 0;
   int bad   = 0;

   // Memory-map model: RAM bytes with written-flags (RAM is never cleared), registers.
   logic [7:0] col_m [2048];
   logic [7:0] code_m[2048];
   logic [7:0] work_m[4096];
   bit         col_v [2048];
   bit         code_v[2048];
   bit         work_v[4096];
   logic [7:0] lo_m  [32];
   logic       hi_m  [32];
   logic       spbk_m, flip_m;

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) begin lo_m[i] = 8'h00; hi_m[i] = 1'b0; end
      spbk_m = 1'b0;
      flip_m = 1'b0;
   endfunction

   function automatic void mw(input logic [15:0] a, input logic [7:0] d);
      int o;
      o = int'(a);
      if (o >= 'hC000 && o < 'hC800)      begin col_m[o-'hC000] = d;  col_v[o-'hC000] = 1'b1; end
      else if (o >= 'hC800 && o < 'hD000) begin code_m[o-'hC800] = d; code_v[o-'hC800] = 1'b1; end
      else if (o >= 'hD000 && o < 'hE000) begin work_m[o-'hD000] = d; work_v[o-'hD000] = 1'b1; end
      else if (o >= 'hE000 && o < 'hE020) lo_m[o-'hE000] = d;
      else if (o >= 'hE020 && o < 'hE040) hi_m[o-'hE020] = d[0];
      else if (o == 'hE043) spbk_m = d[3];
      else if (o == 'hE044) flip_m = d[3];
   endfunction

   // Returns {known, byte} for a CPU read of address a.
   function automatic logic [8:0] mr(input logic [15:0] a);
      int o;
      o = int'(a);
      if (o >= 'hC000 && o < 'hC800) return {col_v[o-'hC000], col_m[o-'hC000]};
      if (o >= 'hC800 && o < 'hD000) return {code_v[o-'hC800], code_m[o-'hC800]};
      if (o >= 'hD000 && o < 'hE000) return {work_v[o-'hD000], work_m[o-'hD000]};
      return 9'h000;
   endfunction

   task automatic tick();
      @(posedge CL);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      vif.CPUMX = 1'b0;
      vif.CPUWR = 1'b0;
   endtask

   // Strobe held for 'hold' cycles; data is corrupted after the first edge so a
   // repeated commit would be visible.
   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input int hold);
      vif.CPUAD = a; vif.CPUWD = d; vif.CPUMX = 1'b1; vif.CPUWR = 1'b1;
      tick();
      mw(a, d);
      vif.CPUWD = ~d;
      repeat (hold - 1) tick();
      idle();
      tick();
   endtask

   task automatic cpu_read(input logic [15:0] a);
      logic [8:0] m;
      logic       dv;
      vif.CPUAD = a; vif.CPUMX = 1'b1; vif.CPUWR = 1'b0;
      dv = (a >= 16'hC000 && a <= 16'hDFFF);
      #1;
      chk("viddv", 16'(vif.VIDDV), 16'(dv));
      m = mr(a);
      tick();
      if (m[8]) chk("vidrd", 16'(vif.VIDRD), 16'(m[7:0]));
      idle();
   endtask

   task automatic fetch(input logic [10:0] va, input logic [7:0] sa, input logic [4:0] r);
      int si;
      VADR = va; SADR = sa; ROW = r;
      si = (spbk_m ? 256 : 0) + int'(sa);
      tick();
      if (col_v[va])  chk("vcol", 16'(VCOL), 16'(col_m[va]));
      if (code_v[va]) chk("vcod", 16'(VCOD), 16'(code_m[va]));
      if (work_v[si]) chk("spdt", 16'(SPDT), 16'(work_m[si]));
      chk("scrl", 16'(SCRL), 16'({hi_m[r], lo_m[r]}));
      chk("spbk", 16'(SPBK), 16'(spbk_m));
      chk("flip", 16'(FLIP), 16'(flip_m));
   endtask

   function automatic logic [15:0] rand_addr();
      logic [15:0] pick [4];
      pick[0] = 16'hE045; pick[1] = 16'hF123; pick[2] = 16'h8000; pick[3] = 16'hBFFF;
      case ($urandom_range(0, 9))
         0: return 16'hC000 + 16'($urandom_range(0, 15));
         1: return 16'hC800 + 16'($urandom_range(0, 15));
         2: return 16'hD000 + 16'($urandom_range(0, 15));
         3: return 16'hD100 + 16'($urandom_range(0, 15));
         4: return 16'hE000 + 16'($urandom_range(0, 63));
         5: return 16'hE043;
         6: return 16'hE044;
         7: return 16'hE040 + 16'($urandom_range(0, 2));
         8: return pick[$urandom_range(0, 3)];
         default: return 16'hDF00 + 16'($urandom_range(0, 15));
      endcase
   endfunction

   initial begin
      RESET = 1'b1; VADR = '0; SADR = '0; ROW = '0;
      vif.CPUAD = '0; vif.CPUWD = '0;
      idle();
      model_reset();
      tick(); tick();
      chk("rst_vidrd", 16'(vif.VIDRD), 16'h0);
      chk("rst_vcol",  16'(VCOL), 16'h0);
      chk("rst_vcod",  16'(VCOD), 16'h0);
      chk("rst_spdt",  16'(SPDT), 16'h0);
      chk("rst_scrl",  16'(SCRL), 16'h0);
      chk("rst_spbk",  16'(SPBK), 16'h0);
      chk("rst_flip",  16'(FLIP), 16'h0);
      RESET = 1'b0;
      tick();

      // Held tile-code write commits once; colour RAM at same index untouched
      cpu_write(16'hC012, 8'h44, 1);
      cpu_write(16'hC812, 8'h5A, 4);
      fetch(11'h012, 8'h00, 5'd0);
      chk("vcod_c812", 16'(VCOD), 16'h5A);
      chk("vcol_c012", 16'(VCOL), 16'h44);

      // CPU read-back and write-only register space
      cpu_write(16'hD1FF, 8'h3C, 2);
      cpu_read(16'hD1FF);
      chk("vidrd_d1ff", 16'(vif.VIDRD), 16'h3C);
      cpu_read(16'hE000);
      cpu_read(16'hC812);

      // Scroll with bit 8
      cpu_write(16'hE005, 8'hA7, 1);
      cpu_write(16'hE025, 8'h01, 1);
      fetch(11'h0, 8'h0, 5'd5);
      chk("scrl_row5", 16'(SCRL), 16'h1A7);
      fetch(11'h0, 8'h0, 5'd6);
      chk("scrl_row6", 16'(SCRL), 16'h000);

      // Sprite bank select and flip
      cpu_write(16'hD105, 8'h99, 1);
      cpu_write(16'hD005, 8'h11, 1);
      cpu_write(16'hE043, 8'h08, 1);
      fetch(11'h0, 8'h05, 5'd0);
      chk("spdt_bank1", 16'(SPDT), 16'h99);
      cpu_write(16'hE043, 8'h00, 1);
      fetch(11'h0, 8'h05, 5'd0);
      chk("spdt_bank0", 16'(SPDT), 16'h11);
      cpu_write(16'hE044, 8'h0F, 2);
      fetch(11'h0, 8'h05, 5'd0);
      chk("flip_set", 16'(FLIP), 16'h1);
      chk("spbk_kept", 16'(SPBK), 16'h0);

      // Same-cycle write and fetch of the same colour byte
      cpu_write(16'hC000, 8'h21, 1);
      VADR = 11'h000;
      vif.CPUAD = 16'hC000; vif.CPUWD = 8'h77; vif.CPUMX = 1'b1; vif.CPUWR = 1'b1;
      tick();
      chk("vcol_collide_old", 16'(VCOL), 16'h21);
      mw(16'hC000, 8'h77);
      idle();
      tick();
      chk("vcol_collide_new", 16'(VCOL), 16'h77);

      // Strobe with CPUMX low must not write
      cpu_write(16'hC001, 8'h10, 1);
      vif.CPUAD = 16'hC001; vif.CPUWD = 8'hEE; vif.CPUMX = 1'b0; vif.CPUWR = 1'b1;
      #1;
      chk("viddv_mx_low", 16'(vif.VIDDV), 16'h0);
      tick(); tick();
      idle();
      fetch(11'h001, 8'h00, 5'd0);
      chk("vcol_mx_low", 16'(VCOL), 16'h10);

      // Reset in the middle of a held scroll write
      ROW = 5'd16;
      cpu_write(16'hE010, 8'h33, 1);
      tick();
      chk("scrl16_pre", 16'(SCRL), 16'h033);
      RESET = 1'b1;
      vif.CPUAD = 16'hE010; vif.CPUWD = 8'h5C; vif.CPUMX = 1'b1; vif.CPUWR = 1'b1;
      tick(); tick();
      model_reset();
      chk("scrl16_in_rst", 16'(SCRL), 16'h000);
      RESET = 1'b0;
      tick();
      mw(16'hE010, 8'h5C);
      chk("scrl16_commit_edge", 16'(SCRL), 16'h000);
      vif.CPUWD = 8'hC5;
      tick();
      chk("scrl16_after", 16'(SCRL), 16'h05C);
      tick();
      chk("scrl16_single", 16'(SCRL), 16'h05C);
      idle();
      tick();
      fetch(11'h012, 8'h05, 5'd16);
      chk("ram_kept_rst", 16'(VCOD), 16'h5A);

      // Randomized mix of writes, reads and fetches
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 2))
            0: cpu_write(rand_addr(), 8'($urandom_range(0, 255)), $urandom_range(1, 3));
            1: cpu_read(rand_addr());
            default: fetch(11'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                           5'($urandom_range(0, 31)));
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gberet_vidbus.md
# gberet_vidbus

Video-side responder for the Green Beret / Mr. Goemon main-CPU bus. It decodes Z80 memory cycles aimed at video resources, owns the colour/tile RAM, work/sprite RAM and the scroll, sprite-bank and flip registers, and returns read data to the CPU. It also serves the tile fetcher, sprite engine and scroll logic in parallel on independent read ports. It sits between the main CPU block and the tile/sprite renderers.

## Interface
Parameters:
- none; the memory map is fixed.

Ports:
- CL  in  1  system clock, rising edge; CPU bus signals are synchronous to it
- RESET  in  1  reset RESET, synchronous, active-high
- CPUMX  in  1  CPU memory request, active-high
- CPUAD  in  16  CPU address
- CPUWR  in  1  CPU write strobe, active-high
- CPUWD  in  8  CPU write data
- VIDDV  out  1  read-data-valid select toward the CPU data mux
- VIDRD  out  8  CPU read data
- VADR  in  11  tile fetch address (tile index)
- VCOL  out  8  colour/attribute byte at VADR
- VCOD  out  8  tile code byte at VADR
- SADR  in  8  sprite RAM fetch address within the active bank
- SPDT  out  8  sprite RAM byte
- ROW  in  5  tile row for scroll lookup
- SCRL  out  9  horizontal scroll for ROW
- SPBK  out  1  active sprite bank
- FLIP  out  1  screen flip

## Operation
- Map, all internal:
  - C000-C7FF colour RAM (2 KB)
  - C800-CFFF tile code RAM (2 KB)
  - D000-DFFF work RAM (4 KB); sprite bank 0 at D000-D0FF, bank 1 at D100-D1FF
  - E000-E01F scroll low bytes; E020-E03F scroll bit 8 (CPUWD[0])
  - E043 sprite bank = CPUWD[3]
  - E044 flip = CPUWD[3]; bits 2:0 belong to the IRQ generator and are ignored here
- Write commit: a write occurs when wr = CPUMX & CPUWR & decoded hit.
  - It commits exactly once, on the first CL edge where wr is high and the registered prior wr is low.
  - A strobe held for N cycles writes once.
- VIDDV = CPUMX & ~CPUWR & (CPUAD in C000-DFFF), combinational. E0xx registers are write-only and read with VIDDV=0.
- VIDRD is registered each CL edge from the RAM addressed by CPUAD and holds while the address is stable.
- VCOL/VCOD are registered reads of colour/code RAM at VADR.
- SPDT is a registered read of work RAM at {3'b000, SPBK, SADR}.
- SCRL is registered: {hi[ROW], lo[ROW]}.
- Unmapped addresses: writes are ignored, and VIDDV stays 0.

## Timing
- Reset values:
  - VIDRD=0, VCOL=0, VCOD=0, SPDT=0, SCRL=0, SPBK=0, FLIP=0
  - all 32 scroll entries = 0
  - write-edge register = 0
  - RAM contents are not cleared.
- Latency:
  - CPU read: 1 CL. Address at edge n gives VIDRD valid after edge n+1.
  - All fetch ports: 1 CL.
  - Register write: visible on SCRL/SPBK/FLIP after the next edge following commit.
- Same-cycle CPU write and fetch-port read of the same byte: the fetch port returns old data; new data appears on the next read.
- SPBK change takes effect for the SPDT read issued on the cycle after commit, never mid-access.
- Reset asserted mid-strobe: no write commits while RESET=1.
  - The edge register is cleared, so a strobe still high at the first non-reset edge commits once.
- CPUMX low: no commit and VIDDV=0; the edge register tracks wr=0.

## Test plan
- Reset, then CPU write 0x5A to C812 (strobe held 4 cycles) -> exactly one commit; VADR=0x012 gives VCOD=0x5A one cycle later; VCOL at 0x012 unchanged.
- CPU read D1FF after writing 0x3C -> VIDDV=1 combinationally; VIDRD=0x3C one cycle after the address is presented; read of E000 gives VIDDV=0.
- Write E005=0xA7 and E025=0x01, set ROW=5 -> SCRL=0x1A7; ROW=6 gives SCRL=0x000.
- Write D105=0x99 and D005=0x11; E043=0x08 then SADR=0x05 -> SPDT=0x99; E043=0x00 -> SPDT=0x11; write E044=0x0F -> FLIP=1, SPBK unchanged.
- Simultaneous CPU write C000=0x77 and VADR=0x000 in the same cycle -> VCOL returns old value, then 0x77 on the following cycle.
- Assert RESET for 2 cycles during a held write to E010 -> scroll lo[16]=0 during reset; after release with the strobe still high, a single commit occurs and SCRL(ROW=16) shows the written value.
